downcounter_timer: RTL and testbench

//  Loadable countdown timer; decrementing counterpart of the saturating up-counter.

---
 rtl/downcounter_timer_pkg.sv | 12 +
 rtl/downcounter_core.sv | 29 ++
 rtl/downcounter_timer.sv | 151 +++++++++++++++
 tb/tb_downcounter_timer.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/downcounter_timer_pkg.sv
// Shared types and defaults for the loadable countdown timer.
package downcounter_timer_pkg;

  localparam int DCT_COUNT_BITS = 3;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    EXPIRED
  } dct_state_e;

endpackage

// File: rtl/downcounter_core.sv
// Loadable saturating down-counter: a load wins over a decrement, and the count
// never wraps below zero.
module downcounter_core
  import downcounter_timer_pkg::*;
#(
  parameter int COUNT_BITS = DCT_COUNT_BITS
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  load,
  input  logic [COUNT_BITS-1:0] load_value,
  input  logic                  dec,
  output logic [COUNT_BITS-1:0] count,
  output logic                  is_one
);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign is_one = (count == COUNT_BITS'(1));

endmodule

// File: rtl/downcounter_timer.sv
// Loadable countdown timer with a one-cycle expiry pulse and a sticky expired flag.
// Define DOWNCOUNTER_TIMER_AUTORELOAD_EN to reload the last start value instead of expiring.
//
// state   | meaning
// IDLE    | waiting for a start value; load_ready high unless abort
// RUN     | counting down on every enabled cycle
// EXPIRED | count reached zero; expired held until expired_ack
module downcounter_timer
  import downcounter_timer_pkg::*;
#(
  parameter int COUNT_BITS = DCT_COUNT_BITS,
  parameter int MAX        = 2**COUNT_BITS - 1
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [COUNT_BITS-1:0] load_value,
  input  logic                  enable,
  input  logic                  abort,
  input  logic                  expired_ack,
  output logic [COUNT_BITS-1:0] count,
  output logic                  busy,
  output logic                  zero_tick,
  output logic                  expired
);

  dct_state_e            state;
  logic [COUNT_BITS-1:0] load_clip;
  logic [COUNT_BITS-1:0] core_value;
  logic                  accept;
  logic                  core_load;
  logic                  core_dec;
  logic                  is_one;
  logic                  terminal;
`ifdef DOWNCOUNTER_TIMER_AUTORELOAD_EN
  logic [COUNT_BITS-1:0] reload;
  logic                  wrap;
`endif

  assign load_ready = (state == IDLE) && !abort;
  assign accept     = load_valid && load_ready;
  assign terminal   = (state == RUN) && enable && is_one;
  assign core_dec   = (state == RUN) && enable;

  // Clipping only exists when MAX is below the natural range of the port.
  generate
    if (MAX >= 2**COUNT_BITS - 1) begin : g_no_clip
      assign load_clip = load_value;
    end else begin : g_clip
      localparam logic [COUNT_BITS-1:0] MAX_VAL = COUNT_BITS'(MAX);
      assign load_clip = (load_value > MAX_VAL) ? MAX_VAL : load_value;
    end
  endgenerate

`ifdef DOWNCOUNTER_TIMER_AUTORELOAD_EN
  assign wrap = terminal && (reload != '0);
`endif

  always_comb begin
    core_load  = 1'b0;
    core_value = '0;
    if (abort) begin
      core_load = 1'b1;
    end else if (accept) begin
      core_load  = 1'b1;
      core_value = load_clip;
`ifdef DOWNCOUNTER_TIMER_AUTORELOAD_EN
    end else if (wrap) begin
      core_load  = 1'b1;
      core_value = reload;
`endif
    end
  end

  downcounter_core #(
    .COUNT_BITS(COUNT_BITS)
  ) u_core (
    .clk       (clk),
    .resetn    (resetn),
    .load      (core_load),
    .load_value(core_value),
    .dec       (core_dec),
    .count     (count),
    .is_one    (is_one)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      zero_tick <= 1'b0;
      expired   <= 1'b0;
      busy      <= 1'b0;
`ifdef DOWNCOUNTER_TIMER_AUTORELOAD_EN
      reload    <= '0;
`endif
    end else if (abort) begin
      state     <= IDLE;
      zero_tick <= 1'b0;
      expired   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      zero_tick <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
`ifdef DOWNCOUNTER_TIMER_AUTORELOAD_EN
            reload <= load_clip;
`endif
            if (load_clip == '0) begin
              state     <= EXPIRED;
              zero_tick <= 1'b1;
              expired   <= 1'b1;
            end else begin
              state <= RUN;
              busy  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (terminal) begin
            zero_tick <= 1'b1;
`ifdef DOWNCOUNTER_TIMER_AUTORELOAD_EN
            if (!wrap) begin
              state   <= EXPIRED;
              expired <= 1'b1;
              busy    <= 1'b0;
            end
`else
            state   <= EXPIRED;
            expired <= 1'b1;
            busy    <= 1'b0;
`endif
          end
        end
        EXPIRED: begin
          if (expired_ack) begin
            state   <= IDLE;
            expired <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          expired <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_downcounter_timer.sv
// Scoreboard bench for downcounter_timer: expectations are derived per episode from
// the pre-drawn enable pattern (tick = the N-th enabled cycle) and checked by a monitor.
module tb_downcounter_timer;

`ifdef DOWNCOUNTER_TIMER_AUTORELOAD_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic       clk;
  logic       resetn;
  logic       load_valid;
  logic       load_ready;
  logic [2:0] load_value;
  logic       enable;
  logic       abort;
  logic       expired_ack;
  logic [2:0] count;
  logic       busy;
  logic       zero_tick;
  logic       expired;

  downcounter_timer dut (
    .clk        (clk),
    .resetn     (resetn),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_value (load_value),
    .enable     (enable),
    .abort      (abort),
    .expired_ack(expired_ack),
    .count      (count),
    .busy       (busy),
    .zero_tick  (zero_tick),
    .expired    (expired)
  );

  typedef struct {
    int cyc;
    int cnt;
    int xp;
    int bsy;
    int rdy;
  } snap_t;

  snap_t snap_q[$];
  int    tick_q[$];
  int    cyc      = 0;
  int    n_checks = 0;
  int    n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  function automatic void chk(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, req);
    end
  endfunction

  function automatic void push_snap(input int c, input int cnt, input int xp, input int bsy,
                                    input int rdy);
    snap_t s;
    s.cyc = c; s.cnt = cnt; s.xp = xp; s.bsy = bsy; s.rdy = rdy;
    snap_q.push_back(s);
  endfunction

  // Monitor: sampled mid-cycle, after the edge numbered cyc.
  always @(negedge clk) begin
    snap_t s;
    int    t;
    while (snap_q.size() > 0 && snap_q[0].cyc < cyc) begin
      s = snap_q.pop_front();
      chk("snapshot_missed", cyc, s.cyc);
    end
    if (snap_q.size() > 0 && snap_q[0].cyc == cyc) begin
      s = snap_q.pop_front();
      chk("count", int'(count), s.cnt);
      chk("expired", int'(expired), s.xp);
      chk("busy", int'(busy), s.bsy);
      chk("load_ready", int'(load_ready), s.rdy);
    end
    if (zero_tick || (tick_q.size() > 0 && tick_q[0] <= cyc)) begin
      if (tick_q.size() == 0) begin
        chk("zero_tick_unexpected", int'(zero_tick), 0);
      end else begin
        t = tick_q.pop_front();
        chk("zero_tick_cycle", zero_tick ? cyc : -1, t);
      end
    end
  end

  task automatic drive(input int lv, input int val, input int en, input int ab, input int ack);
    load_valid  = (lv != 0);
    load_value  = 3'(val);
    enable      = (en != 0);
    abort       = (ab != 0);
    expired_ack = (ack != 0);
    @(posedge clk);
    #1;
  endtask

  // One load/count/finish episode. p_en < 0 selects the fixed 1,0,0 enable pattern.
  // abort_k >= 0 aborts on the edge that samples enable entry abort_k.
  task automatic episode(input int n, input int p_en, input int abort_k, input int hold);
    int en[$];
    int h, ones, last, e;
    bit aborted;
    h = cyc + 1;
    ones = 0;
    last = -1;
    aborted = 1'b0;
    if (AR && abort_k < 0) abort_k = 12;
    if (n > 0) begin
      for (int k = 0; k < 400; k++) begin
        en.push_back(p_en < 0 ? int'(k % 3 == 0) : int'($urandom_range(99) < p_en));
        ones += en[k];
        if (AR ? (k == abort_k) : (ones == n)) break;
      end
      aborted = AR || (abort_k >= 0 && abort_k < en.size());
      last = aborted ? abort_k : en.size() - 1;
    end

    if (n == 0) begin
      push_snap(h, 0, 1, 0, 0);
      tick_q.push_back(h);
    end else begin
      ones = 0;
      for (int j = 0; j <= last; j++) begin
        push_snap(h + j, AR ? n - ones % n : n - ones, 0, 1, 0);
        ones += en[j];
        if (en[j] != 0 && ones % n == 0 && !(aborted && j == last))
          tick_q.push_back(h + 1 + j);
      end
      if (aborted) push_snap(h + last + 1, 0, 0, 0, 1);
      else         push_snap(h + last + 1, 0, 1, 0, 0);
    end
    e = h + last + 1;
    if (!aborted) begin
      for (int i = 1; i <= hold; i++) push_snap(e + i, 0, 1, 0, 0);
      push_snap(e + hold + 1, 0, 0, 0, 1);
    end

    drive(1, n, $urandom_range(1), 0, 0);
    for (int j = 0; j <= last; j++)
      drive($urandom_range(1), $urandom_range(7), en[j], int'(aborted && j == last),
            $urandom_range(1));
    if (!aborted) begin
      for (int i = 0; i < hold; i++)
        drive($urandom_range(1), $urandom_range(7), $urandom_range(1), 0, 0);
      drive($urandom_range(1), $urandom_range(7), $urandom_range(1), 0, 1);
    end
  endtask

  task automatic abort_idle();
    drive(0, 0, 0, 0, 0);
    push_snap(cyc, 0, 0, 0, 0);
    push_snap(cyc + 1, 0, 0, 0, 1);
    drive(1, 5, 1, 1, 0);
    drive(0, 0, 0, 0, 0);
  endtask

  task automatic reset_midrun();
    int h;
    drive(0, 0, 0, 0, 0);
    h = cyc + 1;
    push_snap(h, 3, 0, 1, 0);
    push_snap(h + 1, 2, 0, 1, 0);
    drive(1, 3, 1, 0, 0);
    drive(1, 6, 1, 0, 0);
    @(negedge clk);
    #2;
    load_valid = 1'b0;
    resetn = 1'b0;
    #1;
    chk("midrst_count", int'(count), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_zero_tick", int'(zero_tick), 0);
    chk("midrst_expired", int'(expired), 0);
    #1;
    resetn = 1'b1;
    @(posedge clk);
    #1;
    push_snap(cyc, 0, 0, 0, 1);
    drive(0, 0, 1, 0, 0);
  endtask

  initial begin
    resetn = 1'b1;
    load_valid = 1'b0; load_value = '0; enable = 1'b0; abort = 1'b0; expired_ack = 1'b0;
    #1;
    resetn = 1'b0;
    #1;
    chk("rst_count", int'(count), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_zero_tick", int'(zero_tick), 0);
    chk("rst_expired", int'(expired), 0);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;
    push_snap(cyc, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0);

    episode(5, 100, -1, 3);
    episode(4, -1, -1, 2);
    episode(0, 50, -1, 2);
    episode(6, 100, 3, 0);
    reset_midrun();
    episode(2, 100, 9, 0);
    abort_idle();
    episode(7, 100, -1, 0);
    episode(1, 60, -1, 1);

    for (int r = 0; r < 30; r++) begin
      if ($urandom_range(7) == 0) abort_idle();
      else episode($urandom_range(7), $urandom_range(25, 100),
                   ($urandom_range(3) == 0) ? int'($urandom_range(10)) : -1,
                   $urandom_range(4));
    end

    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    chk("tick_queue_drained", tick_q.size(), 0);
    chk("snap_queue_drained", snap_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
